shift_add_multiplier: RTL



---
 rtl/shift_add_multiplier.sv | 104 ++++++++++
 1 files changed

// File: rtl/shift_add_multiplier.sv
// Sequential unsigned shift-and-add multiplier that reuses an external WIDTH-bit adder.
// Processes one multiplier bit per cycle and builds a 2*WIDTH-bit product in {acc, mq}.
module shift_add_multiplier #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned CNT_W = 6
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    input  logic [WIDTH-1:0]   a,
    input  logic [WIDTH-1:0]   b,
    output logic               busy,
    output logic               done,
    output logic [2*WIDTH-1:0] product,
    output logic [WIDTH-1:0]   add_a,
    output logic [WIDTH-1:0]   add_b,
    output logic               add_cin,
    input  logic [WIDTH-1:0]   add_sum,
    input  logic               add_cout
);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t             state_q, state_d;
    logic [WIDTH-1:0]   acc_q, acc_d;
    logic [WIDTH-1:0]   mq_q, mq_d;
    logic [WIDTH-1:0]   mcand_q, mcand_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [2*WIDTH-1:0] product_q, product_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;

    // State register with synchronous active-low reset
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            acc_q     <= '0;
            mq_q      <= '0;
            mcand_q   <= '0;
            cnt_q     <= '0;
            product_q <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            acc_q     <= acc_d;
            mq_q      <= mq_d;
            mcand_q   <= mcand_d;
            cnt_q     <= cnt_d;
            product_q <= product_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
        end
    end

    // Next-state, datapath and adder operand selection
    always_comb begin
        state_d   = state_q;
        acc_d     = acc_q;
        mq_d      = mq_q;
        mcand_d   = mcand_q;
        cnt_d     = cnt_q;
        product_d = product_q;
        busy_d    = 1'b0;
        done_d    = 1'b0;
        add_a     = '0;
        add_b     = '0;

        case (state_q)
            IDLE, DONE: begin
                state_d = IDLE;
                if (start) begin
                    mcand_d = a;
                    mq_d    = b;
                    acc_d   = '0;
                    cnt_d   = '0;
                    state_d = RUN;
                    busy_d  = 1'b1;
                end
            end
            RUN: begin
                add_a = acc_q;
                add_b = mq_q[0] ? mcand_q : '0;
                // Carry out becomes the new acc MSB so the full product is kept
                {acc_d, mq_d} = {add_cout, add_sum, mq_q[WIDTH-1:1]};
                cnt_d = cnt_q + CNT_W'(1);
                if (cnt_q == CNT_W'(WIDTH - 1)) begin
                    state_d   = DONE;
                    done_d    = 1'b1;
                    product_d = {add_cout, add_sum, mq_q[WIDTH-1:1]};
                end else begin
                    busy_d = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign add_cin = 1'b0;
    assign busy    = busy_q;
    assign done    = done_q;
    assign product = product_q;

endmodule
